// File: rtl/acc_pkg.sv
// Shared types for the accumulator stream source: FSM state encoding and
// timeout counter sizing.
package acc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_COLLECT = 2'd2,
      ST_DONE    = 2'd3
   } acc_state_e;

   // Wide enough to hold TIMEOUT_CYCLES itself; never below one bit.
   function automatic int timeout_cnt_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/handshake_if.sv
// Valid/ready stream with a single data word; a transfer happens only
// when valid and ready are both high.
interface handshake_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;

   modport sender   (output valid, output data, input  ready);
   modport receiver (input  valid, input  data, output ready);
endinterface

// File: rtl/acc_timeout_counter.sv
// Down-counter that flags expiry during the TIMEOUT_CYCLES-th enabled cycle
// after a clear.
module acc_timeout_counter
   import acc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_expired
);

   localparam int CW = timeout_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         cnt_d = LOAD_VAL;
      end else if (i_enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_expired = i_enable && (cnt_q == '0);

endmodule

// File: rtl/acc_stream_source.sv
// Streams an arithmetic operand sequence to an accumulator and checks the
// returned sum against a locally computed expected value.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | waiting for i_start with a non-zero count
//  ST_SEND    | offering operands on tx_if until the last one is acked
//  ST_COLLECT | rx_if.ready high, waiting for the result or timeout
//  ST_DONE    | one-cycle completion pulse, then back to ST_IDLE
module acc_stream_source
   import acc_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int COUNT_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_start,
   input  logic [DATA_WIDTH-1:0]  i_base,
   input  logic [DATA_WIDTH-1:0]  i_step,
   input  logic [COUNT_WIDTH-1:0] i_count,
   input  logic [DATA_WIDTH-1:0]  i_acc_init,
   handshake_if.sender            tx_if,
   handshake_if.receiver          rx_if,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_pass,
   output logic                   o_timeout,
   output logic [DATA_WIDTH-1:0]  o_sum
);

   acc_state_e             state_q,     state_d;
   logic [DATA_WIDTH-1:0]  operand_q,   operand_d;
   logic [DATA_WIDTH-1:0]  step_q,      step_d;
   logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
   logic [DATA_WIDTH-1:0]  expected_q,  expected_d;
   logic                   pass_q,      pass_d;
   logic                   timeout_q,   timeout_d;
   logic [DATA_WIDTH-1:0]  sum_q,       sum_d;

   logic tx_ack;
   logic rx_ack;
   logic expired;

   assign tx_ack = (state_q == ST_SEND)    && tx_if.ready;
   assign rx_ack = (state_q == ST_COLLECT) && rx_if.valid;

   acc_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_enable  (state_q == ST_COLLECT),
      .i_clear   (state_q != ST_COLLECT),
      .o_expired (expired)
   );

   always_comb begin
      state_d     = state_q;
      operand_d   = operand_q;
      step_d      = step_q;
      remaining_d = remaining_q;
      expected_d  = expected_q;
      pass_d      = pass_q;
      timeout_d   = timeout_q;
      sum_d       = sum_q;

      case (state_q)
         ST_IDLE: begin
            if (i_start && (i_count != '0)) begin
               operand_d   = i_base;
               step_d      = i_step;
               remaining_d = i_count;
               expected_d  = i_acc_init;
               pass_d      = 1'b0;
               timeout_d   = 1'b0;
               sum_d       = '0;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_ack) begin
               operand_d   = operand_q + step_q;
               expected_d  = expected_q + operand_q;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == COUNT_WIDTH'(1)) begin
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            // A result arriving in the expiry cycle still counts as a result.
            if (rx_ack) begin
               sum_d   = rx_if.data;
               pass_d  = (rx_if.data == expected_q);
               state_d = ST_DONE;
            end else if (expired) begin
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               state_d   = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         operand_q   <= '0;
         step_q      <= '0;
         remaining_q <= '0;
         expected_q  <= '0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         sum_q       <= '0;
      end else begin
         state_q     <= state_d;
         operand_q   <= operand_d;
         step_q      <= step_d;
         remaining_q <= remaining_d;
         expected_q  <= expected_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         sum_q       <= sum_d;
      end
   end

   assign tx_if.valid = (state_q == ST_SEND);
   assign tx_if.data  = operand_q;
   assign rx_if.ready = (state_q == ST_COLLECT);
   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = (state_q == ST_DONE);
   assign o_pass      = pass_q;
   assign o_timeout   = timeout_q;
   assign o_sum       = sum_q;

endmodule

// File: tb/tb_acc_stream_source.sv
// Directed bench for acc_stream_source with a short timeout so the expiry
// path is reachable in a few cycles.
module tb_acc_stream_source;

   localparam int DW = 32;
   localparam int CW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic [DW-1:0] i_base = '0;
   logic [DW-1:0] i_step = '0;
   logic [CW-1:0] i_count = '0;
   logic [DW-1:0] i_acc_init = '0;
   logic          o_busy, o_done, o_pass, o_timeout;
   logic [DW-1:0] o_sum;

   int total  = 0;
   int passed = 0;
   int n_ready;

   handshake_if #(.DATA_WIDTH(DW)) tx_if ();
   handshake_if #(.DATA_WIDTH(DW)) rx_if ();

   acc_stream_source #(
      .DATA_WIDTH     (DW),
      .COUNT_WIDTH    (CW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (i_start),
      .i_base     (i_base),
      .i_step     (i_step),
      .i_count    (i_count),
      .i_acc_init (i_acc_init),
      .tx_if      (tx_if),
      .rx_if      (rx_if),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_pass     (o_pass),
      .o_timeout  (o_timeout),
      .o_sum      (o_sum)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic start(input logic [DW-1:0] base, input logic [DW-1:0] step,
                        input logic [CW-1:0] cnt, input logic [DW-1:0] init);
      i_base     = base;
      i_step     = step;
      i_count    = cnt;
      i_acc_init = init;
      i_start    = 1'b1;
      tick();
      i_start    = 1'b0;
   endtask

   initial begin
      tx_if.ready = 1'b0;
      rx_if.valid = 1'b0;
      rx_if.data  = '0;

      // Reset state
      #1;
      chk("rst_busy",    o_busy,      0);
      chk("rst_tx_vld",  tx_if.valid, 0);
      chk("rst_rx_rdy",  rx_if.ready, 0);
      chk("rst_done",    o_done,      0);
      chk("rst_pass",    o_pass,      0);
      chk("rst_timeout", o_timeout,   0);
      chk("rst_sum",     o_sum,       0);
      #22 rst_n = 1'b1;
      tick();

      // Start with zero count is ignored
      i_count = '0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("zero_cnt_busy", o_busy, 0);

      // Basic burst 1,2,3,4; result offered early must not be taken in SEND
      tx_if.ready = 1'b1;
      rx_if.valid = 1'b1;
      rx_if.data  = 32'd10;
      start(32'd1, 32'd1, 16'd4, 32'd0);
      chk("b1_busy",   o_busy,      1);
      chk("b1_vld",    tx_if.valid, 1);
      chk("b1_d1",     tx_if.data,  1);
      chk("b1_rxrdy",  rx_if.ready, 0);
      tick(); chk("b1_d2", tx_if.data, 2);
      tick(); chk("b1_d3", tx_if.data, 3);
      tick(); chk("b1_d4", tx_if.data, 4);
      chk("b1_d4_done", o_done, 0);
      tick();
      chk("b1_col_vld", tx_if.valid, 0);
      chk("b1_col_rdy", rx_if.ready, 1);
      tick();
      chk("b1_done",    o_done,    1);
      chk("b1_pass",    o_pass,    1);
      chk("b1_sum",     o_sum,     10);
      chk("b1_timeout", o_timeout, 0);
      tick();
      chk("b1_done_off", o_done, 0);
      chk("b1_idle",     o_busy, 0);
      chk("b1_pass_hold", o_pass, 1);
      rx_if.valid = 1'b0;

      // Backpressure: ready low for 3 cycles while operand 2 is offered
      start(32'd1, 32'd1, 16'd4, 32'd0);
      chk("bp_pass_clr", o_pass, 0);
      chk("bp_sum_clr",  o_sum,  0);
      chk("bp_d1",       tx_if.data, 1);
      tick();
      chk("bp_d2_a", tx_if.data, 2);
      tx_if.ready = 1'b0;
      tick(); chk("bp_d2_b", tx_if.data, 2);
      tick(); chk("bp_d2_c", tx_if.data, 2);
      tick(); chk("bp_d2_d", tx_if.data, 2);
      chk("bp_vld_hold", tx_if.valid, 1);
      tx_if.ready = 1'b1;
      tick(); chk("bp_d3", tx_if.data, 3);
      tick(); chk("bp_d4", tx_if.data, 4);
      tick(); chk("bp_col", rx_if.ready, 1);
      rx_if.valid = 1'b1;
      rx_if.data  = 32'd10;
      tick();
      chk("bp_done", o_done, 1);
      chk("bp_pass", o_pass, 1);
      rx_if.valid = 1'b0;
      tick();

      // Operand and expected wrap modulo 2^32: 5 + FFFFFFFF + 0 = 4
      start(32'hFFFF_FFFF, 32'd1, 16'd2, 32'd5);
      chk("wr_d1", tx_if.data, 32'hFFFF_FFFF);
      tick(); chk("wr_d2", tx_if.data, 32'h0000_0000);
      tick();
      rx_if.valid = 1'b1;
      rx_if.data  = 32'h0000_0004;
      tick();
      chk("wr_done", o_done, 1);
      chk("wr_pass", o_pass, 1);
      chk("wr_sum",  o_sum,  4);
      rx_if.valid = 1'b0;
      tick();

      // Wrong result: 7 + 3 + 5 + 7 = 22, accumulator returns 23
      start(32'd3, 32'd2, 16'd3, 32'd7);
      chk("mm_d1", tx_if.data, 3);
      tick(); chk("mm_d2", tx_if.data, 5);
      tick(); chk("mm_d3", tx_if.data, 7);
      tick();
      rx_if.valid = 1'b1;
      rx_if.data  = 32'd23;
      tick();
      chk("mm_done",    o_done,    1);
      chk("mm_pass",    o_pass,    0);
      chk("mm_timeout", o_timeout, 0);
      chk("mm_sum",     o_sum,     23);
      rx_if.valid = 1'b0;
      tick();

      // Timeout: no result ever offered, DONE follows the 8th COLLECT cycle
      start(32'd0, 32'd0, 16'd1, 32'd0);
      tick();
      n_ready = 0;
      for (int k = 0; k < 20 && o_done !== 1'b1; k++) begin
         if (rx_if.ready === 1'b1) n_ready++;
         tick();
      end
      chk("to_cycles",  n_ready,   TO);
      chk("to_done",    o_done,    1);
      chk("to_timeout", o_timeout, 1);
      chk("to_pass",    o_pass,    0);
      tick();
      chk("to_hold", o_timeout, 1);

      // Result in the expiry cycle wins over the timeout
      start(32'd0, 32'd0, 16'd1, 32'd0);
      chk("tw_to_clr", o_timeout, 0);
      tick();
      for (int k = 0; k < TO - 1; k++) tick();
      chk("tw_rdy", rx_if.ready, 1);
      chk("tw_not_done", o_done, 0);
      rx_if.valid = 1'b1;
      rx_if.data  = 32'd0;
      tick();
      chk("tw_done",    o_done,    1);
      chk("tw_timeout", o_timeout, 0);
      chk("tw_pass",    o_pass,    1);
      rx_if.valid = 1'b0;
      tick();

      // Start pulsed during SEND is ignored: burst stays 10,11,12
      start(32'd10, 32'd1, 16'd3, 32'd0);
      chk("ig_d1", tx_if.data, 10);
      i_base  = 32'd100;
      i_count = 16'd5;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("ig_d2", tx_if.data, 11);
      tick(); chk("ig_d3", tx_if.data, 12);
      tick(); chk("ig_col_vld", tx_if.valid, 0);
      rx_if.valid = 1'b1;
      rx_if.data  = 32'd33;
      tick();
      chk("ig_pass", o_pass, 1);
      chk("ig_sum",  o_sum,  33);
      rx_if.valid = 1'b0;
      tick();

      // Reset mid-SEND abandons the burst immediately
      start(32'd1, 32'd1, 16'd4, 32'd0);
      tick();
      chk("mr_pre_vld", tx_if.valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_vld",  tx_if.valid, 0);
      chk("mr_busy", o_busy,      0);
      chk("mr_sum",  o_sum,       0);
      n_ready = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (o_done === 1'b1) n_ready++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (o_done === 1'b1 || o_busy === 1'b1) n_ready++;
      end
      chk("mr_no_done", n_ready, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/acc_stream_source.md
ACC_STREAM_SOURCE -- requirements
Module: acc_stream_source

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand, sum and expected-value width.
REQ-002 Parameter COUNT_WIDTH, default 16: width of the burst-length field.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum COLLECT cycles allowed before a result is seen.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  burst-start request, honoured only in IDLE.
REQ-007 i_base  input  DATA_WIDTH  first operand.
REQ-008 i_step  input  DATA_WIDTH  operand increment.
REQ-009 i_count  input  COUNT_WIDTH  number of operands in the burst.
REQ-010 i_acc_init  input  DATA_WIDTH  sink accumulator value before the burst.
REQ-011 tx_if  handshake_if.sender  -  operand stream: this block drives valid and data, and observes ready.
REQ-012 rx_if  handshake_if.receiver  -  result stream: this block drives ready, and observes valid and data.
REQ-013 o_busy  output  1  high in every state other than IDLE.
REQ-014 o_done  output  1  one-cycle pulse at burst completion.
REQ-015 o_pass  output  1  captured result equals expected; held until next start.
REQ-016 o_timeout  output  1  COLLECT timed out; held until next start.
REQ-017 o_sum  output  DATA_WIDTH  last captured result; held until next start.

Function
REQ-018 Transfer on either interface SHALL occur only in a cycle where valid and ready are both high (the interface ack).
REQ-019 FSM states SHALL be IDLE, SEND, COLLECT, DONE, with DONE lasting exactly one cycle and then returning to IDLE.
REQ-020 In IDLE, i_start=1 with i_count!=0 SHALL latch base, step, count and i_acc_init, clear o_pass, o_timeout and o_sum, and enter SEND next cycle.
REQ-021 i_start SHALL be ignored when i_count==0 or when the FSM is not in IDLE.
REQ-022 In SEND, tx_if.valid SHALL be 1 and tx_if.data SHALL equal the current operand; the first operand is i_base.
REQ-023 tx_if.data SHALL remain stable while valid=1 and no ack has occurred (backpressure hold).
REQ-024 On each tx ack, operand <= operand+step (mod 2^DATA_WIDTH), expected <= expected+operand (mod 2^DATA_WIDTH), and remaining <= remaining-1.
REQ-025 The tx ack of the last operand SHALL move the FSM to COLLECT; tx_if.valid SHALL be 0 from the next cycle.
REQ-026 In COLLECT, rx_if.ready SHALL be 1; rx_if.ready SHALL be 0 in all other states.
REQ-027 An rx ack in COLLECT SHALL load o_sum<=rx data and o_pass<=(rx data==expected), and move the FSM to DONE.
REQ-028 COLLECT SHALL count cycles; if TIMEOUT_CYCLES elapse without an rx ack, set o_timeout=1 and o_pass=0 and go to DONE.
REQ-029 If an rx ack coincides with the timeout cycle, the ack SHALL win and o_timeout SHALL stay 0.
REQ-030 o_done SHALL be 1 exactly in the DONE cycle.
REQ-031 rx valid outside COLLECT SHALL be ignored and SHALL NOT be acked.
REQ-032 Operand and expected arithmetic SHALL wrap modulo 2^DATA_WIDTH with no overflow flag.

Reset
REQ-033 rst_n low SHALL immediately force IDLE and clear every output and every internal register, including tx_if.valid and rx_if.ready.
REQ-034 Reset asserted mid-burst SHALL abandon the burst with no o_done pulse.

Structure
REQ-035 The state enum typedef SHALL live in shared package acc_pkg, alongside the accumulator's other shared types.
REQ-036 The COLLECT timeout counter SHALL be the single sub-module acc_timeout_counter (inputs: enable, clear; output: expired).

Verification
REQ-037 base=1, step=1, count=4, init=0, rx returns 10: tx data 1,2,3,4 -> o_done pulse, o_pass=1, o_sum=10.
REQ-038 Same burst with tx ready low for 3 cycles while operand 2 is offered -> tx_if.data holds 2 throughout, then 3,4 follow; o_pass=1.
REQ-039 base=32'hFFFF_FFFF, step=1, count=2, init=5, rx returns 32'h0000_0004 -> tx data FFFF_FFFF, 0000_0000; o_pass=1.
REQ-040 count=3 burst with rx returning expected+1 -> o_pass=0, o_timeout=0; TIMEOUT_CYCLES=8 with rx valid never high -> o_done on the 8th COLLECT cycle, o_timeout=1.
REQ-041 i_start pulsed during SEND -> ignored with latched values unchanged; rst_n low during SEND -> tx_if.valid=0 and o_busy=0 immediately, and no o_done pulse.
